// File: rtl/pattern_matching_module_if.sv
// Command/status bundle between a requester and the pattern matcher.
// The requester holds DATA_VALID with the command until READY_STATUS rises.
interface pattern_matching_module_if;
  logic [63:0] INP_DATA;
  logic [15:0] INP_CONTROL;
  logic        DATA_VALID;
  logic        READY_STATUS;
  logic        ACCEPTED_STATUS;

  modport master (
    output INP_DATA, INP_CONTROL, DATA_VALID,
    input  READY_STATUS, ACCEPTED_STATUS
  );

  modport slave (
    input  INP_DATA, INP_CONTROL, DATA_VALID,
    output READY_STATUS, ACCEPTED_STATUS
  );
endinterface

// File: rtl/pattern_matching_module.sv
// Streaming byte pattern matcher: loads up to a 16-byte pattern, then scans
// 64-bit data words one byte per cycle against a 16-byte sliding history.
module pattern_matching_module (
  input  logic                       clk,
  input  logic                       reset,
  pattern_matching_module_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_MATCH = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t      state_reg, state_next;
  logic [63:0] data_reg;
  logic [1:0]  op_reg;
  logic        first_reg;
  logic [2:0]  last_idx_reg;
  logic [2:0]  idx_reg, idx_next;
  logic        ready_reg, ready_next;
  logic        accepted_reg;
  logic [4:0]  pat_len_reg;
  logic [4:0]  seen_reg;
  logic [7:0]  pat_reg  [16];
  logic [7:0]  hist_reg [16];

  logic [7:0]  cur_byte;
  logic        restart;
  logic [4:0]  len_base;
  logic [4:0]  seen_base;
  logic [4:0]  seen_new;
  logic [7:0]  hist_new [16];
  logic [3:0]  cmp_idx  [16];
  logic [15:0] byte_eq;
  logic        match_hit;
  logic [3:0]  cnt_in;
  logic [2:0]  last_idx_in;
  logic        unused_ctrl;

  assign bus.READY_STATUS    = ready_reg;
  assign bus.ACCEPTED_STATUS = accepted_reg;

  assign cnt_in      = bus.INP_CONTROL[3:0];
  assign last_idx_in = (cnt_in == 4'd0 || cnt_in > 4'd8) ? 3'd7 : 3'(cnt_in - 4'd1);
  assign unused_ctrl = ^bus.INP_CONTROL[13:5];

  assign cur_byte  = data_reg[{idx_reg, 3'b000} +: 8];
  // FIRST-flagged commands reset their context right before byte 0 is used.
  assign restart   = first_reg && (idx_reg == 3'd0);
  assign len_base  = restart ? 5'd0 : pat_len_reg;
  assign seen_base = restart ? 5'd0 : seen_reg;
  assign seen_new  = (seen_base == 5'd16) ? 5'd16 : seen_base + 5'd1;

  // hist_new[0] is the newest byte; pattern byte j lines up with hist_new[L-1-j].
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_hist
      if (gi == 0) begin : g_head
        assign hist_new[gi] = cur_byte;
      end else begin : g_tail
        assign hist_new[gi] = restart ? 8'h00 : hist_reg[gi-1];
      end
      assign cmp_idx[gi] = 4'(pat_len_reg - 5'd1 - 5'(gi));
      assign byte_eq[gi] = (5'(gi) >= pat_len_reg) || (pat_reg[gi] == hist_new[cmp_idx[gi]]);
    end
  endgenerate

  assign match_hit = (pat_len_reg != 5'd0) && (seen_new >= pat_len_reg) && (&byte_eq);

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    ready_next = 1'b0;
    case (state_reg)
      IDLE: begin
        idx_next = 3'd0;
        if (bus.DATA_VALID) state_next = BUSY;
      end
      BUSY: begin
        if (op_reg == OP_NOP || op_reg == OP_CLEAR || idx_reg == last_idx_reg)
          state_next = DONE;
        else
          idx_next = idx_reg + 3'd1;
      end
      DONE: begin
        if (bus.DATA_VALID) ready_next = 1'b1;
        else                state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      idx_reg      <= 3'd0;
      ready_reg    <= 1'b0;
      accepted_reg <= 1'b0;
      pat_len_reg  <= 5'd0;
      seen_reg     <= 5'd0;
      data_reg     <= 64'd0;
      op_reg       <= OP_NOP;
      first_reg    <= 1'b0;
      last_idx_reg <= 3'd0;
      for (int i = 0; i < 16; i++) begin
        pat_reg[i]  <= 8'h00;
        hist_reg[i] <= 8'h00;
      end
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      ready_reg <= ready_next;

      if (state_reg == IDLE && bus.DATA_VALID) begin
        data_reg     <= bus.INP_DATA;
        op_reg       <= bus.INP_CONTROL[15:14];
        first_reg    <= bus.INP_CONTROL[4];
        last_idx_reg <= last_idx_in;
      end

      if (state_reg == BUSY) begin
        case (op_reg)
          OP_LOAD: begin
            if (restart) begin
              for (int i = 0; i < 16; i++) hist_reg[i] <= 8'h00;
              seen_reg     <= 5'd0;
              accepted_reg <= 1'b0;
            end
            // Bytes past a full 16-byte pattern are dropped.
            if (len_base < 5'd16) begin
              pat_reg[len_base[3:0]] <= cur_byte;
              pat_len_reg            <= len_base + 5'd1;
            end else begin
              pat_len_reg <= len_base;
            end
          end
          OP_MATCH: begin
            for (int i = 0; i < 16; i++) hist_reg[i] <= hist_new[i];
            seen_reg     <= seen_new;
            accepted_reg <= match_hit | (accepted_reg & ~restart);
          end
          OP_CLEAR: begin
            for (int i = 0; i < 16; i++) hist_reg[i] <= 8'h00;
            seen_reg     <= 5'd0;
            pat_len_reg  <= 5'd0;
            accepted_reg <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pattern_matching_module.sv
// Directed bench: the driver queues expected latency/status per command and
// a negedge monitor checks them when READY_STATUS rises.
module tb_pattern_matching_module;
  logic clk;
  logic reset;
  int   edge_cnt;
  int   checks;
  int   passes;
  logic ready_prev;

  typedef struct {
    string name;
    int    lat;
    logic  acc;
    int    cap;
  } exp_t;

  exp_t exp_q[$];

  pattern_matching_module_if bus_if();

  pattern_matching_module dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Monitor: one scoreboard entry per READY_STATUS rising edge.
  initial ready_prev = 1'b0;
  always @(negedge clk) begin
    if (bus_if.READY_STATUS === 1'b1 && ready_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("txn %s: latency=%0d accepted=%0b", e.name, edge_cnt - e.cap, bus_if.ACCEPTED_STATUS);
        check({e.name, "_latency"}, edge_cnt - e.cap, e.lat);
        check({e.name, "_accepted"}, int'(bus_if.ACCEPTED_STATUS), int'(e.acc));
      end
    end
    ready_prev = bus_if.READY_STATUS;
  end

  task automatic send(input string name, input logic [1:0] op, input logic first,
                      input logic [3:0] cnt, input logic [63:0] data, input logic exp_acc);
    exp_t e;
    int   n;
    int   k;
    n = (cnt == 4'd0 || cnt > 4'd8) ? 8 : int'(cnt);
    e.name = name;
    e.lat  = (op == 2'b01 || op == 2'b10) ? n + 1 : 2;
    e.acc  = exp_acc;
    e.cap  = edge_cnt + 1;
    exp_q.push_back(e);
    bus_if.INP_DATA    = data;
    bus_if.INP_CONTROL = {op, 9'd0, first, cnt};
    bus_if.DATA_VALID  = 1'b1;
    for (k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus_if.READY_STATUS) break;
    end
    if (k == 40) check({name, "_timeout"}, 0, 1);
    bus_if.DATA_VALID  = 1'b0;
    bus_if.INP_DATA    = 64'hDEAD_BEEF_DEAD_BEEF;
    bus_if.INP_CONTROL = 16'hFFFF;
    @(posedge clk); #1;
    check({name, "_ready_drop"}, int'(bus_if.READY_STATUS), 0);
  endtask

  localparam logic [1:0] NOP = 2'b00, LOAD = 2'b01, MATCH = 2'b10, CLEAR = 2'b11;
  localparam logic [63:0] W_ABC    = 64'h0000_0000_0043_4241;
  localparam logic [63:0] W_XXABC  = 64'h7878_7843_4241_7878;
  localparam logic [63:0] W_Z      = 64'h7A7A_7A7A_7A7A_7A7A;
  localparam logic [63:0] W_ABCD   = 64'h0000_0000_4443_4241;
  localparam logic [63:0] W_END_AB = 64'h4241_7878_7878_7878;
  localparam logic [63:0] W_CD     = 64'h7878_7878_7878_4443;
  localparam logic [63:0] W_A8     = 64'h4141_4141_4141_4141;
  localparam logic [63:0] W_B8     = 64'h4242_4242_4242_4242;

  initial begin
    checks = 0;
    passes = 0;
    reset  = 1'b1;
    bus_if.DATA_VALID  = 1'b0;
    bus_if.INP_DATA    = 64'd0;
    bus_if.INP_CONTROL = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", int'(bus_if.READY_STATUS), 0);
    check("reset_accepted", int'(bus_if.ACCEPTED_STATUS), 0);
    reset = 1'b0;

    send("load_abc",       LOAD,  1'b1, 4'd3, W_ABC,    1'b0);
    send("match_xxabc",    MATCH, 1'b1, 4'd8, W_XXABC,  1'b1);
    send("match_z_cnt15",  MATCH, 1'b0, 4'hF, W_Z,      1'b1);
    send("nop_keeps",      NOP,   1'b0, 4'd0, W_Z,      1'b1);
    send("clear",          CLEAR, 1'b0, 4'd5, W_Z,      1'b0);
    send("match_after_clr",MATCH, 1'b1, 4'd8, W_XXABC,  1'b0);

    send("load_abcd",      LOAD,  1'b1, 4'd4, W_ABCD,   1'b0);
    send("match_end_ab",   MATCH, 1'b1, 4'd8, W_END_AB, 1'b0);
    send("match_cd",       MATCH, 1'b0, 4'd8, W_CD,     1'b1);
    send("load_keep_acc",  LOAD,  1'b0, 4'd1, 64'h51,   1'b1);

    send("load_a8",        LOAD,  1'b1, 4'd0, W_A8,     1'b0);
    send("load_a1",        LOAD,  1'b0, 4'd1, 64'h41,   1'b0);
    send("match_a8",       MATCH, 1'b1, 4'd0, W_A8,     1'b0);
    send("match_a1",       MATCH, 1'b0, 4'd1, 64'h41,   1'b1);

    send("load16_a",       LOAD,  1'b1, 4'd0, W_A8,     1'b0);
    send("load16_b",       LOAD,  1'b0, 4'd0, W_A8,     1'b0);
    send("load_overflow",  LOAD,  1'b0, 4'd0, W_B8,     1'b0);
    send("match16_w0",     MATCH, 1'b1, 4'd0, W_A8,     1'b0);
    send("match16_w1",     MATCH, 1'b0, 4'd0, W_A8,     1'b1);

    // Abort a MATCH mid-BUSY with reset.
    bus_if.INP_DATA    = W_A8;
    bus_if.INP_CONTROL = {MATCH, 9'd0, 1'b0, 4'd8};
    bus_if.DATA_VALID  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    bus_if.DATA_VALID = 1'b0;
    @(posedge clk); #1;
    check("midbusy_reset_ready", int'(bus_if.READY_STATUS), 0);
    check("midbusy_reset_accepted", int'(bus_if.ACCEPTED_STATUS), 0);
    reset = 1'b0;

    send("nop_after_reset",  NOP,   1'b0, 4'd0, W_A8, 1'b0);
    send("match_after_rst",  MATCH, 1'b1, 4'd0, W_A8, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/pattern_matching_module.md
PATTERN_MATCHING_MODULE -- requirements
Module: pattern_matching_module

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: INP_DATA  input  64  eight data bytes; byte k = INP_DATA[8k+7:8k]; byte 0 is processed first.
REQ-004 SHALL have port: INP_CONTROL  input  16  command word: [15:14] opcode, [4] FIRST flag, [3:0] byte count, other bits ignored.
REQ-005 SHALL have port: DATA_VALID  input  1  requester strobe; INP_DATA and INP_CONTROL are valid while high.
REQ-006 SHALL have port: READY_STATUS  output  1  registered; command consumed (data accepted).
REQ-007 SHALL have port: ACCEPTED_STATUS  output  1  registered, sticky; pattern found in stream.

Function
REQ-008 SHALL decode opcode as: 00 NOP, 01 LOAD_PATTERN, 10 MATCH_DATA, 11 CLEAR.
REQ-009 SHALL take byte count n = INP_CONTROL[3:0] when 1..8; count 0 or >8 SHALL mean n = 8.
REQ-010 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-011 IDLE: when DATA_VALID=1, SHALL capture INP_DATA and INP_CONTROL into internal registers and go to BUSY next cycle; later input changes SHALL have no effect.
REQ-012 BUSY: SHALL process one captured byte per cycle, bytes 0..n-1, then enter DONE; NOP and CLEAR SHALL spend exactly one BUSY cycle.
REQ-013 DONE: READY_STATUS SHALL be 1; SHALL stay in DONE while DATA_VALID=1.
REQ-014 In DONE with DATA_VALID=0, SHALL return to IDLE and deassert READY_STATUS on the next edge; a new command SHALL be accepted only from IDLE.
REQ-015 Latency: capture at edge 0, READY_STATUS high after edge n+1 for LOAD/MATCH and after edge 2 for NOP/CLEAR.
REQ-016 LOAD_PATTERN with FIRST=1 SHALL first set pattern length to 0, clear stream history and clear ACCEPTED_STATUS.
REQ-017 LOAD_PATTERN SHALL append each byte to pattern storage (16 bytes max); bytes beyond 16 SHALL be discarded silently.
REQ-018 MATCH_DATA with FIRST=1 SHALL clear stream history and ACCEPTED_STATUS before its first byte.
REQ-019 MATCH_DATA SHALL shift each byte into a 16-byte history and increment a seen-count saturating at 16.
REQ-020 A match SHALL occur on a byte when pattern length L>=1, seen-count (including this byte) >=L, and the last L history bytes equal pattern bytes 0..L-1 in order.
REQ-021 On a match, ACCEPTED_STATUS SHALL be 1 from the next edge and hold until reset, CLEAR, or FIRST-flagged LOAD/MATCH.
REQ-022 History SHALL persist across MATCH_DATA commands without FIRST, so matches spanning 64-bit words SHALL be detected.
REQ-023 L=0 SHALL never produce a match.
REQ-024 CLEAR SHALL zero pattern length, history, seen-count and ACCEPTED_STATUS.
REQ-025 NOP SHALL only perform the handshake; no state change other than FSM.
REQ-026 LOAD_PATTERN without FIRST SHALL keep existing history and ACCEPTED_STATUS.

Reset
REQ-027 reset=1 at a rising edge SHALL force IDLE, READY_STATUS=0, ACCEPTED_STATUS=0, pattern length 0, history and seen-count 0, overriding any command in progress.
REQ-028 After reset deasserts, a command held on DATA_VALID SHALL be captured at the first edge in IDLE.

Verification
REQ-029 Load "ABC" (opcode 01, FIRST=1, n=3, bytes 0x41,0x42,0x43) -> READY_STATUS high 4 cycles after capture, low one cycle after DATA_VALID drops; ACCEPTED_STATUS=0.
REQ-030 Then MATCH "xxABCxxx" (opcode 10, FIRST=1, n=8) -> ACCEPTED_STATUS=1 no later than READY_STATUS assertion, stays 1 through subsequent non-matching MATCH words.
REQ-031 Pattern "ABCD"; MATCH word ending "..AB" then word starting "CD.." (FIRST=0) -> ACCEPTED_STATUS=1 only during second word.
REQ-032 Count field 0 with data "AAAAAAAA", pattern "AAAAAAAAA" (9 bytes, two loads) -> no match after one word, match on byte 0 of next "A" word.
REQ-033 CLEAR after a match -> ACCEPTED_STATUS=0, READY_STATUS high 2 cycles after capture; following MATCH of same data -> no match (L=0).
REQ-034 Assert reset while in BUSY mid-MATCH -> next cycle READY_STATUS=0, ACCEPTED_STATUS=0, FSM IDLE.
